// File: rtl/cr16_pkg.sv
// Shared definitions for the CR16 execute controller: opcode/PSR widths,
// PSR bit positions and the controller state encoding.
package cr16_pkg;

    localparam int OPCODE_W  = 4;
    localparam int REG_IDX_W = 4;
    localparam int PSR_W     = 5;

    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_t;

    // True when an operand index hits the register about to be written back.
    function automatic logic idx_match(input logic [REG_IDX_W-1:0] rd_idx,
                                       input logic [REG_IDX_W-1:0] wb_idx,
                                       input logic                 wb_live);
        return wb_live && (rd_idx == wb_idx);
    endfunction

endpackage

// File: rtl/cr16_regfile.sv
// CR16 register file: NUM_REGS x DATA_W, three combinational read ports,
// one synchronous write port, asynchronous active-low clear.
module cr16_regfile
    import cr16_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_nreset,
    input  logic [REG_IDX_W-1:0] i_ra_addr,
    output logic [DATA_W-1:0]    o_ra_data,
    input  logic [REG_IDX_W-1:0] i_rb_addr,
    output logic [DATA_W-1:0]    o_rb_data,
    input  logic [REG_IDX_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0]    o_dbg_data,
    input  logic                 i_we,
    input  logic [REG_IDX_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]    i_wdata
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    // Storage: cleared asynchronously, written on the rising edge.
    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read ports: indices beyond the configured depth read as zero.
    always_comb begin
        o_ra_data  = '0;
        o_rb_data  = '0;
        o_dbg_data = '0;
        if (int'(i_ra_addr) < NUM_REGS) begin
            o_ra_data = r_mem[i_ra_addr];
        end else begin
            o_ra_data = '0;
        end
        if (int'(i_rb_addr) < NUM_REGS) begin
            o_rb_data = r_mem[i_rb_addr];
        end else begin
            o_rb_data = '0;
        end
        if (int'(i_dbg_addr) < NUM_REGS) begin
            o_dbg_data = r_mem[i_dbg_addr];
        end else begin
            o_dbg_data = '0;
        end
    end

endmodule

// File: rtl/cr16_exec_ctrl.sv
// CR16 execute controller: IDLE/EXEC/WB sequencing of one ALU instruction.
// Optional macro CR16_EXEC_BYPASS_EN: accept in WB with result forwarding.
module cr16_exec_ctrl
    import cr16_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16
) (
    input  logic                 I_CLK,
    input  logic                 I_NRESET,
    input  logic                 I_INSTR_VALID,
    output logic                 O_INSTR_READY,
    input  logic [OPCODE_W-1:0]  I_OPCODE,
    input  logic [REG_IDX_W-1:0] I_RDEST,
    input  logic [REG_IDX_W-1:0] I_RSRC,
    input  logic                 I_IMM_SEL,
    input  logic [DATA_W-1:0]    I_IMM,
    input  logic                 I_WB_EN,
    output logic [DATA_W-1:0]    O_ALU_A,
    output logic [DATA_W-1:0]    O_ALU_B,
    output logic [OPCODE_W-1:0]  O_ALU_OPCODE,
    output logic                 O_ALU_ENABLE,
    input  logic [DATA_W-1:0]    I_ALU_C,
    input  logic [PSR_W-1:0]     I_ALU_STATUS,
    output logic                 O_WB_VALID,
    output logic [REG_IDX_W-1:0] O_WB_ADDR,
    output logic [DATA_W-1:0]    O_WB_DATA,
    output logic [PSR_W-1:0]     O_PSR,
    input  logic [REG_IDX_W-1:0] I_DBG_ADDR,
    output logic [DATA_W-1:0]    O_DBG_DATA
);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_ready;
    logic                  r_alu_en;
    logic                  r_wb_valid;
    logic [OPCODE_W-1:0]   r_opcode;
    logic [REG_IDX_W-1:0]  r_rdest;
    logic                  r_wb_en;
    logic [DATA_W-1:0]     r_alu_a;
    logic [DATA_W-1:0]     r_alu_b;
    logic [PSR_W-1:0]      r_psr;

    logic                  w_accept;
    logic                  w_rf_we;
    logic                  w_next_ready;
    logic [DATA_W-1:0]     w_rf_a;
    logic [DATA_W-1:0]     w_rf_b;
    logic [DATA_W-1:0]     w_src_a;
    logic [DATA_W-1:0]     w_src_b;
    logic [DATA_W-1:0]     w_opnd_b;

    assign w_accept = I_INSTR_VALID && r_ready;
    assign w_rf_we  = (r_state == ST_WB) && r_wb_en;

    cr16_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .i_clk      (I_CLK),
        .i_nreset   (I_NRESET),
        .i_ra_addr  (I_RDEST),
        .o_ra_data  (w_rf_a),
        .i_rb_addr  (I_RSRC),
        .o_rb_data  (w_rf_b),
        .i_dbg_addr (I_DBG_ADDR),
        .o_dbg_data (O_DBG_DATA),
        .i_we       (w_rf_we),
        .i_waddr    (r_rdest),
        .i_wdata    (I_ALU_C)
    );

    // Operand selection; the bypass build forwards the result being written back.
    always_comb begin
        w_src_a = w_rf_a;
        w_src_b = w_rf_b;
`ifdef CR16_EXEC_BYPASS_EN
        if (idx_match(I_RDEST, r_rdest, w_rf_we)) begin
            w_src_a = I_ALU_C;
        end else begin
            w_src_a = w_rf_a;
        end
        if (idx_match(I_RSRC, r_rdest, w_rf_we)) begin
            w_src_b = I_ALU_C;
        end else begin
            w_src_b = w_rf_b;
        end
`endif
    end

    assign w_opnd_b = I_IMM_SEL ? I_IMM : w_src_b;

    // State register.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and the ready level that the next state implies.
    always_comb begin
        w_next_state = r_state;
        w_next_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_EXEC;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_next_state = ST_WB;
            end
            ST_WB: begin
`ifdef CR16_EXEC_BYPASS_EN
                if (w_accept) begin
                    w_next_state = ST_EXEC;
                end else begin
                    w_next_state = ST_IDLE;
                end
`else
                w_next_state = ST_IDLE;
`endif
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
`ifdef CR16_EXEC_BYPASS_EN
        w_next_ready = (w_next_state == ST_IDLE) || (w_next_state == ST_WB);
`else
        w_next_ready = (w_next_state == ST_IDLE);
`endif
    end

    // Registered handshake and strobe outputs, decoded from the next state.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            r_ready    <= 1'b1;
            r_alu_en   <= 1'b0;
            r_wb_valid <= 1'b0;
        end else begin
            r_ready    <= w_next_ready;
            r_alu_en   <= (w_next_state == ST_EXEC);
            r_wb_valid <= (w_next_state == ST_WB) && r_wb_en;
        end
    end

    // Instruction latch at accept; PSR capture at the edge leaving WB.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            r_opcode <= '0;
            r_rdest  <= '0;
            r_wb_en  <= 1'b0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_psr    <= '0;
        end else begin
            if (w_accept) begin
                r_opcode <= I_OPCODE;
                r_rdest  <= I_RDEST;
                r_wb_en  <= I_WB_EN;
                r_alu_a  <= w_src_a;
                r_alu_b  <= w_opnd_b;
            end
            if (r_state == ST_WB) begin
                r_psr <= I_ALU_STATUS;
            end
        end
    end

    assign O_INSTR_READY = r_ready;
    assign O_ALU_ENABLE  = r_alu_en;
    assign O_ALU_A       = r_alu_a;
    assign O_ALU_B       = r_alu_b;
    assign O_ALU_OPCODE  = r_opcode;
    assign O_WB_VALID    = r_wb_valid;
    assign O_WB_ADDR     = r_rdest;
    assign O_WB_DATA     = I_ALU_C;
    assign O_PSR         = r_psr;

endmodule

// File: tb/tb_cr16_exec_ctrl.sv
// Directed self-checking bench for cr16_exec_ctrl with a stand-in ALU and a
// scoreboard of expected writebacks.
module tb_cr16_exec_ctrl;

`ifdef CR16_EXEC_BYPASS_EN
    localparam int  EXP_GAP   = 2;
    localparam logic BYP_READY = 1'b1;
`else
    localparam int  EXP_GAP   = 3;
    localparam logic BYP_READY = 1'b0;
`endif

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        logic        wb_en;
        logic [4:0]  psr;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  opcode = 4'd0;
    logic [3:0]  rdest = 4'd0;
    logic [3:0]  rsrc = 4'd0;
    logic        imm_sel = 1'b0;
    logic [15:0] imm = 16'd0;
    logic        wb_en = 1'b0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_opcode;
    logic        alu_enable;
    logic [15:0] alu_c = 16'd0;
    logic [4:0]  alu_status = 5'd0;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [4:0]  psr;
    logic [3:0]  dbg_addr = 4'd0;
    logic [15:0] dbg_data;

    int          n_vec = 0;
    int          n_fail = 0;
    logic [15:0] m_reg [16];
    logic [4:0]  m_psr;
    exp_t        sb [$];

    cr16_exec_ctrl #(.DATA_W(16), .NUM_REGS(16)) dut (
        .I_CLK         (clk),
        .I_NRESET      (nreset),
        .I_INSTR_VALID (instr_valid),
        .O_INSTR_READY (instr_ready),
        .I_OPCODE      (opcode),
        .I_RDEST       (rdest),
        .I_RSRC        (rsrc),
        .I_IMM_SEL     (imm_sel),
        .I_IMM         (imm),
        .I_WB_EN       (wb_en),
        .O_ALU_A       (alu_a),
        .O_ALU_B       (alu_b),
        .O_ALU_OPCODE  (alu_opcode),
        .O_ALU_ENABLE  (alu_enable),
        .I_ALU_C       (alu_c),
        .I_ALU_STATUS  (alu_status),
        .O_WB_VALID    (wb_valid),
        .O_WB_ADDR     (wb_addr),
        .O_WB_DATA     (wb_data),
        .O_PSR         (psr),
        .I_DBG_ADDR    (dbg_addr),
        .O_DBG_DATA    (dbg_data)
    );

    always #5 clk = ~clk;

    // ALU reference: {N,Z,F,L,C,result}; opcode 0001 adds, anything else subtracts.
    function automatic logic [20:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        logic [16:0] s;
        logic        f;
        if (op == 4'b0001) begin
            s = {1'b0, a} + {1'b0, b};
            f = (a[15] == b[15]) && (s[15] != a[15]);
        end else begin
            s = {1'b0, a} - {1'b0, b};
            f = (a[15] != b[15]) && (s[15] != a[15]);
        end
        return {s[15], (s[15:0] == 16'd0), f, (a < b), s[16], s[15:0]};
    endfunction

    // Stand-in ALU: result and flags registered one cycle after enable.
    always @(posedge clk) begin
        if (alu_enable) begin
            {alu_status, alu_c} <= alu_model(alu_opcode, alu_a, alu_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t make_exp(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic sel,
                                      input logic [15:0] im, input logic wen,
                                      input logic [15:0] a, input logic [15:0] rsv);
        exp_t        e;
        logic [20:0] r;
        e.a     = a;
        e.b     = sel ? im : rsv;
        r       = alu_model(op, e.a, e.b);
        e.data  = r[15:0];
        e.psr   = r[20:16];
        e.addr  = rd;
        e.wb_en = wen;
        return e;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                         input logic sel, input logic [15:0] im, input logic wen);
        opcode = op; rdest = rd; rsrc = rs; imm_sel = sel; imm = im; wb_en = wen;
        instr_valid = 1'b1;
    endtask

    // Compares one WB-state cycle against the head of the scoreboard.
    task automatic check_wb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_wb_valid"}, 32'(wb_valid), 32'(e.wb_en));
            check({tag, "_wb_addr"}, 32'(wb_addr), 32'(e.addr));
            check({tag, "_wb_data"}, 32'(wb_data), 32'(e.data));
            if (e.wb_en) m_reg[e.addr] = e.data;
            m_psr = e.psr;
        end
    endtask

    task automatic do_instr(input string tag, input logic [3:0] op, input logic [3:0] rd,
                            input logic [3:0] rs, input logic sel, input logic [15:0] im,
                            input logic wen);
        exp_t e;
        e = make_exp(op, rd, rs, sel, im, wen, m_reg[rd], m_reg[rs]);
        sb.push_back(e);
        @(negedge clk);
        drive(op, rd, rs, sel, im, wen);
        dbg_addr = rd;
        check({tag, "_ready_idle"}, 32'(instr_ready), 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check({tag, "_alu_en"}, 32'(alu_enable), 32'd1);
        check({tag, "_alu_a"}, 32'(alu_a), 32'(e.a));
        check({tag, "_alu_b"}, 32'(alu_b), 32'(e.b));
        check({tag, "_alu_op"}, 32'(alu_opcode), 32'(op));
        check({tag, "_ready_exec"}, 32'(instr_ready), 32'd0);
        @(posedge clk); #1;
        check({tag, "_alu_en_wb"}, 32'(alu_enable), 32'd0);
        check({tag, "_dbg_old"}, 32'(dbg_data), 32'(m_reg[rd]));
        check_wb(tag);
        @(posedge clk); #1;
        check({tag, "_wb_idle"}, 32'(wb_valid), 32'd0);
        check({tag, "_dbg_new"}, 32'(dbg_data), 32'(m_reg[rd]));
        check({tag, "_psr"}, 32'(psr), 32'(m_psr));
    endtask

    task automatic reset_model();
        for (int i = 0; i < 16; i++) m_reg[i] = 16'd0;
        m_psr = 5'd0;
        sb.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 32'(instr_ready), 32'd1);
        check({tag, "_psr"}, 32'(psr), 32'd0);
        check({tag, "_alu_en"}, 32'(alu_enable), 32'd0);
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        int   gap;
        logic acc;
        exp_t ea;
        exp_t eb;

        reset_model();
        #12;
        check_reset_state("por");
        @(negedge clk);
        nreset = 1'b1;

        // Basic ADDU immediate into R1.
        do_instr("addu_imm", 4'b0001, 4'd1, 4'd0, 1'b1, 16'h0005, 1'b1);
        dbg_addr = 4'd1; #1;
        check("r1_is_5", 32'(dbg_data), 32'h5);

        // R0 is an ordinary register.
        do_instr("r0_write", 4'b0001, 4'd0, 4'd0, 1'b1, 16'hA5A5, 1'b1);

        // Wraparound to zero sets Z.
        do_instr("r2_ffff", 4'b0001, 4'd2, 4'd0, 1'b1, 16'hFFFF, 1'b1);
        do_instr("r1_to_1", 4'b0010, 4'd1, 4'd0, 1'b1, 16'h0004, 1'b1);
        do_instr("addu_wrap", 4'b0001, 4'd2, 4'd1, 1'b0, 16'h0000, 1'b1);
        dbg_addr = 4'd2; #1;
        check("r2_wrap_zero", 32'(dbg_data), 32'h0);
        check("psr_z_set", 32'(psr[3]), 32'd1);

        // Compare: PSR updated, no register write.
        do_instr("r3_load", 4'b0001, 4'd3, 4'd0, 1'b1, 16'h1234, 1'b1);
        do_instr("cmp_nowb", 4'b0010, 4'd3, 4'd0, 1'b1, 16'h2000, 1'b0);
        dbg_addr = 4'd3; #1;
        check("r3_kept", 32'(dbg_data), 32'h1234);

        // Mid-flight asynchronous reset discards the instruction.
        @(negedge clk);
        drive(4'b0001, 4'd5, 4'd0, 1'b1, 16'h7777, 1'b1);
        @(posedge clk); #2;
        instr_valid = 1'b0;
        nreset = 1'b0;
        #1;
        check_reset_state("midrst");
        reset_model();
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i); #1;
            check($sformatf("rst_r%0d", i), 32'(dbg_data), 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_wb", 32'(wb_valid), 32'd0);
        dbg_addr = 4'd5; #1;
        check("midrst_r5", 32'(dbg_data), 32'd0);

        // Back-to-back dependent pair with valid held high.
        do_instr("r1_5", 4'b0001, 4'd1, 4'd0, 1'b1, 16'h0005, 1'b1);
        ea = make_exp(4'b0001, 4'd1, 4'd0, 1'b1, 16'h0001, 1'b1, m_reg[1], m_reg[0]);
        eb = make_exp(4'b0001, 4'd2, 4'd1, 1'b0, 16'h0000, 1'b1, m_reg[2], ea.data);
        sb.push_back(ea);
        sb.push_back(eb);
        @(negedge clk);
        drive(4'b0001, 4'd1, 4'd0, 1'b1, 16'h0001, 1'b1);
        check("b2b_ready_a", 32'(instr_ready), 32'd1);
        @(posedge clk); #1;
        drive(4'b0001, 4'd2, 4'd1, 1'b0, 16'h0000, 1'b1);
        gap = 0;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) begin
            @(negedge clk);
            if (k == 0) check("b2b_ready_exec", 32'(instr_ready), 32'd0);
            if (k == 1) check("b2b_ready_wb", 32'(instr_ready), 32'(BYP_READY));
            if (wb_valid) check_wb("b2b_a");
            acc = instr_ready;
            @(posedge clk);
            gap++;
        end
        #1;
        instr_valid = 1'b0;
        check("b2b_gap", 32'(gap), 32'(EXP_GAP));
        check("b2b_fwd_b", 32'(alu_b), 32'h0006);
        check("b2b_alu_a", 32'(alu_a), 32'(eb.a));
        check("b2b_alu_en", 32'(alu_enable), 32'd1);
        @(posedge clk); #1;
        check_wb("b2b_b");
        @(posedge clk); #1;
        dbg_addr = 4'd2; #1;
        check("b2b_r2", 32'(dbg_data), 32'(m_reg[2]));
        check("b2b_r2_is_6", 32'(dbg_data), 32'h0006);
        dbg_addr = 4'd1; #1;
        check("b2b_r1", 32'(dbg_data), 32'h0006);
        check("b2b_psr", 32'(psr), 32'(m_psr));
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
